// File: rtl/store_buffer.sv
// Write-buffering store buffer: queues core writes, drains them to memory, and serves reads.
// Optional read forwarding from buffered entries is enabled by defining STORE_BUFFER_FORWARD_EN.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_en_i,
   input  logic        wr_en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2
   } state_t;

   logic [31:0]      addr_q_r [DEPTH];
   logic [31:0]      data_q_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   state_t           state_r;
   state_t           state_nx_s;

   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic             rd_pend_s;
   logic             rd_issue_ok_s;
   logic             fwd_s;
   logic [31:0]      fwd_data_s;

   logic             ack_nx_s;
   logic [31:0]      data_nx_s;
   logic             mem_rd_en_nx_s;
   logic             mem_wr_en_nx_s;
   logic [31:0]      mem_addr_nx_s;
   logic [31:0]      mem_data_nx_s;

   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign empty_s   = (count_r == CNT_W'(0));
   assign pop_s     = (state_r == DRAIN) && mem_ack_i;
   // A slot popped this cycle may be refilled in the same cycle, so a full buffer never stalls a drain ack.
   assign push_s    = wr_en_i && !ack_o && (state_r != READ) && (!full_s || pop_s);
   assign rd_pend_s = rd_en_i && !wr_en_i && !ack_o;

`ifdef STORE_BUFFER_FORWARD_EN
   logic             hit_s;
   logic [PTR_W-1:0] idx_s;

   // Scan oldest to youngest so the last match wins (youngest data).
   always_comb begin
      hit_s      = 1'b0;
      fwd_data_s = 32'h0000_0000;
      idx_s      = rd_ptr_r;
      for (int i = 0; i < DEPTH; i++) begin
         idx_s = rd_ptr_r + PTR_W'(i);
         if ((CNT_W'(i) < count_r) && (addr_q_r[idx_s] == addr_i)) begin
            hit_s      = 1'b1;
            fwd_data_s = data_q_r[idx_s];
         end else begin
            hit_s      = hit_s;
            fwd_data_s = fwd_data_s;
         end
      end
   end

   assign fwd_s         = rd_pend_s && hit_s && (state_r != READ);
   assign rd_issue_ok_s = !hit_s;
`else
   assign fwd_s         = 1'b0;
   assign fwd_data_s    = 32'h0000_0000;
   assign rd_issue_ok_s = empty_s;
`endif

   // Buffer storage: write the tail entry on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q_r[i] <= 32'h0000_0000;
            data_q_r[i] <= 32'h0000_0000;
         end
      end else if (push_s) begin
         addr_q_r[wr_ptr_r] <= addr_i;
         data_q_r[wr_ptr_r] <= data_i;
      end
   end

   // Pointers and occupancy count; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state: pending reads take priority over starting another drain.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (rd_pend_s && rd_issue_ok_s) begin
               state_nx_s = READ;
            end else if (!empty_s) begin
               state_nx_s = DRAIN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         DRAIN: begin
            if (mem_ack_i) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DRAIN;
            end
         end
         READ: begin
            if (mem_ack_i) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = READ;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM outputs, computed from the next state so the registered memory port matches the state.
   always_comb begin
      mem_rd_en_nx_s = 1'b0;
      mem_wr_en_nx_s = 1'b0;
      mem_addr_nx_s  = 32'h0000_0000;
      mem_data_nx_s  = 32'h0000_0000;
      case (state_nx_s)
         DRAIN: begin
            mem_wr_en_nx_s = 1'b1;
            mem_addr_nx_s  = addr_q_r[rd_ptr_r];
            mem_data_nx_s  = data_q_r[rd_ptr_r];
         end
         READ: begin
            mem_rd_en_nx_s = 1'b1;
            mem_addr_nx_s  = addr_i;
         end
         IDLE: begin
            mem_rd_en_nx_s = 1'b0;
            mem_wr_en_nx_s = 1'b0;
         end
         default: begin
            mem_rd_en_nx_s = 1'b0;
            mem_wr_en_nx_s = 1'b0;
         end
      endcase

      ack_nx_s = push_s || fwd_s || ((state_r == READ) && mem_ack_i);
      if ((state_r == READ) && mem_ack_i) begin
         data_nx_s = mem_data_i;
      end else if (fwd_s) begin
         data_nx_s = fwd_data_s;
      end else begin
         data_nx_s = data_o;
      end
   end

   // Registered core and memory-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_o       <= 1'b0;
         data_o      <= 32'h0000_0000;
         mem_rd_en_o <= 1'b0;
         mem_wr_en_o <= 1'b0;
         mem_addr_o  <= 32'h0000_0000;
         mem_data_o  <= 32'h0000_0000;
      end else begin
         ack_o       <= ack_nx_s;
         data_o      <= data_nx_s;
         mem_rd_en_o <= mem_rd_en_nx_s;
         mem_wr_en_o <= mem_wr_en_nx_s;
         mem_addr_o  <= mem_addr_nx_s;
         mem_data_o  <= mem_data_nx_s;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); honours STORE_BUFFER_FORWARD_EN.
module tb_store_buffer;

   logic        clk;
   logic        rst_n;
   logic        rd_en_i;
   logic        wr_en_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        ack_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;

   int total;
   int bad;

   store_buffer #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_en_i     (rd_en_i),
      .wr_en_i     (wr_en_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .ack_o       (ack_o),
      .mem_rd_en_o (mem_rd_en_o),
      .mem_wr_en_o (mem_wr_en_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_data_i  (mem_data_i),
      .mem_ack_i   (mem_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic ok);
      int k;
      ok      = 1'b0;
      k       = 0;
      wr_en_i = 1'b1;
      addr_i  = a;
      data_i  = d;
      while (!ok && k < 20) begin
         @(negedge clk);
         if (ack_o) ok = 1'b1;
         k++;
      end
      wr_en_i = 1'b0;
   endtask

   task automatic wait_drain(output logic ok);
      int k;
      ok = mem_wr_en_o;
      k  = 0;
      while (!ok && k < 20) begin
         @(negedge clk);
         ok = mem_wr_en_o;
         k++;
      end
   endtask

   task automatic drain_one(input logic [31:0] ea, input logic [31:0] ed);
      logic ok;
      wait_drain(ok);
      check_val("drain_en", 32'(ok), 32'd1);
      check_val("drain_addr", mem_addr_o, ea);
      check_val("drain_data", mem_data_o, ed);
      check_val("drain_no_rd", 32'(mem_rd_en_o), 32'd0);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
   endtask

   initial begin
      logic ok;
      logic seen;
      int   k;
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      rd_en_i    = 1'b0;
      wr_en_i    = 1'b0;
      addr_i     = 32'h0;
      data_i     = 32'h0;
      mem_data_i = 32'h0;
      mem_ack_i  = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_ack", 32'(ack_o), 32'd0);
      check_val("rst_data", data_o, 32'h0);
      check_val("rst_mem_en", {30'd0, mem_rd_en_o, mem_wr_en_o}, 32'd0);
      check_val("rst_mem_addr", mem_addr_o, 32'h0);
      check_val("rst_mem_data", mem_data_o, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write: ack next cycle, then held drain request until mem ack.
      wr_en_i = 1'b1;
      addr_i  = 32'h10;
      data_i  = 32'hAAAA_0001;
      @(negedge clk);
      check_val("w1_ack", 32'(ack_o), 32'd1);
      check_val("w1_count", 32'(dut.count_r), 32'd1);
      wr_en_i = 1'b0;
      @(negedge clk);
      check_val("w1_ack_pulse", 32'(ack_o), 32'd0);
      check_val("w1_mem_wr", 32'(mem_wr_en_o), 32'd1);
      check_val("w1_mem_addr", mem_addr_o, 32'h10);
      repeat (3) @(negedge clk);
      check_val("w1_hold_wr", 32'(mem_wr_en_o), 32'd1);
      check_val("w1_hold_addr", mem_addr_o, 32'h10);
      drain_one(32'h10, 32'hAAAA_0001);
      check_val("w1_count0", 32'(dut.count_r), 32'd0);
      check_val("w1_wr_low", 32'(mem_wr_en_o), 32'd0);

      // Fill to DEPTH, fifth write stalls until one drain completes.
      for (int i = 0; i < 4; i++) begin
         do_write(32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), ok);
         check_val("fill_ack", 32'(ok), 32'd1);
      end
      check_val("fill_count", 32'(dut.count_r), 32'd4);
      wr_en_i = 1'b1;
      addr_i  = 32'h110;
      data_i  = 32'hB000_0004;
      seen    = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ack_o) seen = 1'b1;
      end
      check_val("full_hold", 32'(seen), 32'd0);
      check_val("full_head", mem_addr_o, 32'h100);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      check_val("full_ack", 32'(ack_o), 32'd1);
      check_val("full_count", 32'(dut.count_r), 32'd4);
      wr_en_i = 1'b0;
      for (int i = 1; i < 5; i++) begin
         drain_one(32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      end
      check_val("full_empty", 32'(dut.count_r), 32'd0);

      // Two writes to one address followed by a read of it.
      do_write(32'h20, 32'h1, ok);
      check_val("fw_w1", 32'(ok), 32'd1);
      do_write(32'h20, 32'h2, ok);
      check_val("fw_w2", 32'(ok), 32'd1);
      rd_en_i = 1'b1;
      addr_i  = 32'h20;
`ifdef STORE_BUFFER_FORWARD_EN
      @(negedge clk);
      check_val("fw_ack", 32'(ack_o), 32'd1);
      check_val("fw_data", data_o, 32'h2);
      check_val("fw_no_rd", 32'(mem_rd_en_o), 32'd0);
      rd_en_i = 1'b0;
      drain_one(32'h20, 32'h1);
      drain_one(32'h20, 32'h2);
      check_val("fw_no_rd_end", 32'(mem_rd_en_o), 32'd0);
`else
      drain_one(32'h20, 32'h1);
      check_val("rd_wait_ack", 32'(ack_o), 32'd0);
      drain_one(32'h20, 32'h2);
      k = 0;
      while (!mem_rd_en_o && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("rd_issue", 32'(mem_rd_en_o), 32'd1);
      check_val("rd_addr", mem_addr_o, 32'h20);
      check_val("rd_excl", 32'(mem_wr_en_o), 32'd0);
      check_val("rd_no_ack", 32'(ack_o), 32'd0);
      mem_data_i = 32'h2;
      mem_ack_i  = 1'b1;
      @(negedge clk);
      mem_ack_i  = 1'b0;
      mem_data_i = 32'h0;
      check_val("rd_ack", 32'(ack_o), 32'd1);
      check_val("rd_data", data_o, 32'h2);
      check_val("rd_done", 32'(mem_rd_en_o), 32'd0);
      rd_en_i = 1'b0;
      @(negedge clk);
      check_val("rd_ack_pulse", 32'(ack_o), 32'd0);
`endif

      // Reset while draining with three entries buffered.
      for (int i = 0; i < 3; i++) begin
         do_write(32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), ok);
      end
      wait_drain(ok);
      check_val("rs_drain", 32'(ok), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rs_mem_en", {30'd0, mem_rd_en_o, mem_wr_en_o}, 32'd0);
      check_val("rs_mem_addr", mem_addr_o, 32'h0);
      check_val("rs_mem_data", mem_data_o, 32'h0);
      check_val("rs_data", data_o, 32'h0);
      check_val("rs_ack", 32'(ack_o), 32'd0);
      check_val("rs_count", 32'(dut.count_r), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      check_val("rs_stray_ack", 32'(ack_o), 32'd0);
      @(negedge clk);
      check_val("rs_stray_ack2", 32'(ack_o), 32'd0);
      check_val("rs_idle_wr", 32'(mem_wr_en_o), 32'd0);
      check_val("rs_count2", 32'(dut.count_r), 32'd0);

      // Read+write together is a write; then push/pop together across the pointer wrap.
      rd_en_i = 1'b1;
      do_write(32'h400, 32'hD000_0000, ok);
      check_val("rw_ack", 32'(ok), 32'd1);
      check_val("rw_count", 32'(dut.count_r), 32'd1);
      check_val("rw_no_rd", 32'(mem_rd_en_o), 32'd0);
      rd_en_i = 1'b0;
      do_write(32'h404, 32'hD000_0001, ok);
      do_write(32'h408, 32'hD000_0002, ok);
      check_val("wp_wr_ptr3", 32'(dut.wr_ptr_r), 32'd3);
      drain_one(32'h400, 32'hD000_0000);
      wait_drain(ok);
      check_val("wp_head", mem_addr_o, 32'h404);
      wr_en_i   = 1'b1;
      addr_i    = 32'h40C;
      data_i    = 32'hD000_0003;
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0;
      wr_en_i   = 1'b0;
      check_val("wp_ack", 32'(ack_o), 32'd1);
      check_val("wp_count", 32'(dut.count_r), 32'd2);
      check_val("wp_wr_wrap", 32'(dut.wr_ptr_r), 32'd0);
      drain_one(32'h408, 32'hD000_0002);
      drain_one(32'h40C, 32'hD000_0003);
      check_val("wp_rd_wrap", 32'(dut.rd_ptr_r), 32'd0);
      check_val("wp_empty", 32'(dut.count_r), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
